approx_prod_accumulator: RTL and testbench

Downstream consumer of the 32x32 unsigned approximate multipliers: it takes the 64-bit product stream, accumulates products into a wide sum per packet, counts the beats, and flags overflow. It returns one result per packet through a valid/ready handshake. It is the dot-product / MAC back end used to measure the accuracy of approximate multipliers at the application level. Throughput is one product per cycle, with a one-cycle bubble per packet.

---
 rtl/approx_prod_accumulator_if.sv | 26 ++
 rtl/approx_prod_accumulator.sv | 102 ++++++++++
 tb/tb_approx_prod_accumulator.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/approx_prod_accumulator_if.sv
// Product-stream in / packet-result out handshake bundle for the accumulator.
// The slave side is the accumulator; the master side is the producer/consumer.
interface approx_prod_accumulator_if #(
    parameter int PW = 64,
    parameter int AW = 72
);
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_prod;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [15:0]   out_count;
    logic          out_ovf;

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/approx_prod_accumulator.sv
// Per-packet product accumulator: sums, counts and flags overflow, result valid one cycle after the last beat.
// in_ready drops for at least one cycle per packet (HOLD) until the result is taken with out_ready.
module approx_prod_accumulator #(
    parameter int PW  = 64,
    parameter int AW  = 72,
    parameter int SAT = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    approx_prod_accumulator_if.slave    bus
);
    typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [15:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] out_sum_q, out_sum_d;
    logic [15:0]   out_count_q, out_count_d;
    logic          out_ovf_q, out_ovf_d;

    logic          beat;
    logic [AW:0]   sum_ext;
    logic [AW-1:0] acc_upd;
    logic [15:0]   count_upd;
    logic          ovf_upd;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        beat    = bus.in_valid && (state_q == ACC);
        sum_ext = {1'b0, acc_q} + (AW+1)'(bus.in_prod);
        ovf_upd = ovf_q | sum_ext[AW];
        // Sticky ovf keeps a saturated accumulator pinned for the rest of the packet
        if ((SAT != 0) && ovf_upd) begin
            acc_upd = {AW{1'b1}};
        end else begin
            acc_upd = sum_ext[AW-1:0];
        end
        count_upd = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

        if (state_q == ACC) begin
            if (beat) begin
                if (bus.in_last) begin
                    out_sum_d   = acc_upd;
                    out_count_d = count_upd;
                    out_ovf_d   = ovf_upd;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    count_d     = '0;
                    ovf_d       = 1'b0;
                    state_d     = HOLD;
                end else begin
                    acc_d   = acc_upd;
                    count_d = count_upd;
                    ovf_d   = ovf_upd;
                end
            end
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_d = 1'b0;
                state_d     = ACC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_approx_prod_accumulator.sv
// Directed bench: one wide saturating instance plus 64-bit saturating and wrapping instances on a shared stream.
module tb_approx_prod_accumulator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_prod = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    approx_prod_accumulator_if #(.PW(64), .AW(72)) ifa ();
    approx_prod_accumulator_if #(.PW(64), .AW(64)) ifs ();
    approx_prod_accumulator_if #(.PW(64), .AW(64)) ifw ();

    assign ifa.in_valid = in_valid;  assign ifa.in_prod = in_prod;
    assign ifa.in_last  = in_last;   assign ifa.out_ready = out_ready;
    assign ifs.in_valid = in_valid;  assign ifs.in_prod = in_prod;
    assign ifs.in_last  = in_last;   assign ifs.out_ready = out_ready;
    assign ifw.in_valid = in_valid;  assign ifw.in_prod = in_prod;
    assign ifw.in_last  = in_last;   assign ifw.out_ready = out_ready;

    approx_prod_accumulator #(.PW(64), .AW(72), .SAT(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    approx_prod_accumulator #(.PW(64), .AW(64), .SAT(1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(ifs.slave));
    approx_prod_accumulator #(.PW(64), .AW(64), .SAT(0)) dut_w (.clk(clk), .rst_n(rst_n), .bus(ifw.slave));

    typedef struct {
        int          n;
        logic [63:0] b0, b1, b2;
        logic [71:0] s72;
        logic [63:0] ss, sw;
        logic [15:0] c;
        logic        o72, os, ow;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [63:0] p, input logic l);
        in_valid = 1'b1; in_prod = p; in_last = l;
        step();
        in_valid = 1'b0; in_prod = '0; in_last = 1'b0;
    endtask

    task automatic chk_res(input string nm, input logic [71:0] s72, input logic [63:0] ss,
                           input logic [63:0] sw, input logic [15:0] c,
                           input logic o72, input logic os, input logic ow);
        chk({nm, " valid_a"}, 72'(ifa.out_valid), 72'd1);
        chk({nm, " valid_s"}, 72'(ifs.out_valid), 72'd1);
        chk({nm, " valid_w"}, 72'(ifw.out_valid), 72'd1);
        chk({nm, " in_ready_a"}, 72'(ifa.in_ready), 72'd0);
        chk({nm, " sum_a"}, ifa.out_sum, s72);
        chk({nm, " sum_s"}, 72'(ifs.out_sum), 72'(ss));
        chk({nm, " sum_w"}, 72'(ifw.out_sum), 72'(sw));
        chk({nm, " count_a"}, 72'(ifa.out_count), 72'(c));
        chk({nm, " count_s"}, 72'(ifs.out_count), 72'(c));
        chk({nm, " count_w"}, 72'(ifw.out_count), 72'(c));
        chk({nm, " ovf_a"}, 72'(ifa.out_ovf), 72'(o72));
        chk({nm, " ovf_s"}, 72'(ifs.out_ovf), 72'(os));
        chk({nm, " ovf_w"}, 72'(ifw.out_ovf), 72'(ow));
    endtask

    task automatic chk_released(input string nm);
        chk({nm, " drop_valid_a"}, 72'(ifa.out_valid), 72'd0);
        chk({nm, " drop_valid_w"}, 72'(ifw.out_valid), 72'd0);
        chk({nm, " ready_back_a"}, 72'(ifa.in_ready), 72'd1);
        chk({nm, " ready_back_s"}, 72'(ifs.in_ready), 72'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] b;
        logic [63:0] ones;
        ones = '1;

        vecs[0] = '{3, 64'd5, 64'd7, 64'd11, 72'd23, 64'd23, 64'd23, 16'd3, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{2, ones, 64'd2, 64'd0, 72'h1_0000_0000_0000_0001, ones, 64'd1, 16'd2, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1, 64'd3, 64'd0, 64'd0, 72'd3, 64'd3, 64'd3, 16'd1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1, ones, 64'd0, 64'd0, 72'(ones), ones, ones, 16'd1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{3, ones, ones, ones, 72'h2_FFFF_FFFF_FFFF_FFFD, ones,
                    64'hFFFF_FFFF_FFFF_FFFD, 16'd3, 1'b0, 1'b1, 1'b1};

        // Reset held with random inputs
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'($urandom); in_last = 1'($urandom);
            in_prod = {$urandom, $urandom}; out_ready = 1'($urandom);
            step();
            chk("rst out_valid", 72'(ifa.out_valid), 72'd0);
            chk("rst out_sum", ifa.out_sum, 72'd0);
            chk("rst out_count", 72'(ifa.out_count), 72'd0);
            chk("rst out_ovf", 72'(ifa.out_ovf), 72'd0);
            chk("rst in_ready", 72'(ifa.in_ready), 72'd1);
        end
        in_valid = 1'b0; in_last = 1'b0; in_prod = '0; out_ready = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("idle out_valid", 72'(ifa.out_valid), 72'd0);
            chk("idle out_sum", ifa.out_sum, 72'd0);
            chk("idle in_ready", 72'(ifa.in_ready), 72'd1);
        end

        // Table-driven packets with out_ready high
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                b = (k == 0) ? vecs[i].b0 : (k == 1) ? vecs[i].b1 : vecs[i].b2;
                beat(b, k == vecs[i].n - 1);
            end
            chk_res($sformatf("vec%0d", i), vecs[i].s72, vecs[i].ss, vecs[i].sw,
                    vecs[i].c, vecs[i].o72, vecs[i].os, vecs[i].ow);
            step();
            chk_released($sformatf("vec%0d", i));
        end

        // Backpressure on a single-beat packet
        out_ready = 1'b0;
        beat(ones, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("bp valid", 72'(ifa.out_valid), 72'd1);
            chk("bp sum", ifa.out_sum, 72'(ones));
            chk("bp in_ready", 72'(ifa.in_ready), 72'd0);
            in_valid = 1'b1; in_prod = 64'd77; in_last = 1'b1;
            step();
        end
        in_valid = 1'b0; in_prod = '0; in_last = 1'b0;
        chk("bp still valid", 72'(ifa.out_valid), 72'd1);
        chk("bp sum held", ifa.out_sum, 72'(ones));
        chk("bp count held", 72'(ifa.out_count), 72'd1);
        out_ready = 1'b1;
        step();
        chk_released("bp");
        chk("bp sum kept", ifa.out_sum, 72'(ones));

        // Mid-packet reset drops the partial packet
        beat(64'd9, 1'b0);
        beat(64'd9, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst out_sum", ifa.out_sum, 72'd0);
        chk("midrst out_valid", 72'(ifa.out_valid), 72'd0);
        chk("midrst in_ready", 72'(ifa.in_ready), 72'd1);
        step();
        rst_n = 1'b1;
        beat(64'd4, 1'b1);
        chk_res("midrst", 72'd4, 64'd4, 64'd4, 16'd1, 1'b0, 1'b0, 1'b0);
        step();
        chk_released("midrst");

        // Gapped stream; in_last and junk data on idle cycles must be ignored
        for (int k = 0; k < 10; k++) begin
            beat(64'd1, k == 9);
            if (k < 9) begin
                in_last = 1'b1; in_prod = 64'hDEAD_BEEF;
                step();
                in_last = 1'b0; in_prod = '0;
            end
        end
        chk_res("gaps", 72'd10, 64'd10, 64'd10, 16'd10, 1'b0, 1'b0, 1'b0);
        step();
        chk_released("gaps");

        // Beat count saturation
        for (int k = 0; k < 70000; k++) begin
            beat(64'd1, k == 69999);
        end
        chk_res("countsat", 72'd70000, 64'd70000, 64'd70000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        step();
        chk_released("countsat");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
